// File: rtl/keyboard_pkg.sv
// Shared PS/2 Set-2 constants, action ids, decoder states
// and the scancode-to-action map used by the scheduler.
package keyboard_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BREAK  = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;

   localparam logic [3:0] ACT_P1_UP    = 4'd0;
   localparam logic [3:0] ACT_P1_DOWN  = 4'd1;
   localparam logic [3:0] ACT_P1_LEFT  = 4'd2;
   localparam logic [3:0] ACT_P1_RIGHT = 4'd3;
   localparam logic [3:0] ACT_P1_BOMB  = 4'd4;
   localparam logic [3:0] ACT_P2_UP    = 4'd5;
   localparam logic [3:0] ACT_P2_DOWN  = 4'd6;
   localparam logic [3:0] ACT_P2_LEFT  = 4'd7;
   localparam logic [3:0] ACT_P2_RIGHT = 4'd8;
   localparam logic [3:0] ACT_P2_BOMB  = 4'd9;

   localparam int unsigned NUM_ACT = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } dec_state_e;

   typedef struct packed {
      logic       hit;
      logic [3:0] id;
   } act_map_t;

   function automatic act_map_t map_code(
      input logic [7:0] code,
      input logic       ext
   );
      act_map_t m;
      m.hit = 1'b1;
      m.id  = ACT_P1_UP;
      if (!ext) begin
         case (code)
            8'h1D:   m.id = ACT_P1_UP;
            8'h1B:   m.id = ACT_P1_DOWN;
            8'h1C:   m.id = ACT_P1_LEFT;
            8'h23:   m.id = ACT_P1_RIGHT;
            8'h29:   m.id = ACT_P1_BOMB;
            default: m.hit = 1'b0;
         endcase
      end else begin
         case (code)
            8'h75:   m.id = ACT_P2_UP;
            8'h72:   m.id = ACT_P2_DOWN;
            8'h6B:   m.id = ACT_P2_LEFT;
            8'h74:   m.id = ACT_P2_RIGHT;
            8'h14:   m.id = ACT_P2_BOMB;
            default: m.hit = 1'b0;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/action_event_fifo.sv
// Synchronous FIFO with a valid/ready read port.
// Head data is held in storage registers; no write-to-read bypass.
module action_event_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [LVL_W-1:0] level_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [LVL_W-1:0] cnt_q;
   logic             pop, wr_en;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == LVL_W'(DEPTH));
   assign valid_o = !empty_o;
   assign level_o = cnt_q;
   assign data_o  = valid_o ? mem_q[rd_q] : '0;

   assign pop   = valid_o & ready_i;
   // When full, a same-cycle pop frees the head slot the write lands in.
   assign wr_en = push_i & (!full_o | pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + PTR_W'(1);
         if (pop)   rd_q <= rd_q + PTR_W'(1);
         cnt_q <= cnt_q + LVL_W'(wr_en) - LVL_W'(pop);
      end
   end

endmodule

// File: rtl/keyboard_action_scheduler.sv
// PS/2 Set-2 decoder mapping two players' keys to actions,
// tracking held keys and queueing press/release events.
module keyboard_action_scheduler
   import keyboard_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [31:0]        keycode_in,
   input  logic               ev_ready,
   output logic               ev_valid,
   output logic               ev_press,
   output logic [3:0]         ev_action,
   output logic [NUM_ACT-1:0] key_state,
   output logic [LEVEL_W-1:0] fifo_level,
   output logic               overflow
);

   dec_state_e         state_q, state_d;
   logic [31:0]        prev_q;
   logic [NUM_ACT-1:0] key_state_q, key_state_d;
   logic               overflow_q;

   logic       new_byte, do_make, do_brk, is_ext;
   logic       press_ev, rel_ev, push, held;
   logic       fifo_full, fifo_empty;
   logic [7:0] b;
   logic [4:0] fifo_dout;
   act_map_t   m;
   logic [NUM_ACT-1:0] mask;

   assign b        = keycode_in[7:0];
   assign new_byte = (keycode_in != prev_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (new_byte) begin
         unique case (state_q)
            ST_IDLE:
               if (b == PS2_EXT)        state_d = ST_EXT;
               else if (b == PS2_BREAK) state_d = ST_BRK;
               else                     state_d = ST_IDLE;
            ST_EXT:
               if (b == PS2_BREAK)      state_d = ST_EXT_BRK;
               else if (b == PS2_EXT)   state_d = ST_EXT;
               else                     state_d = ST_IDLE;
            ST_BRK:
               if (b == PS2_EXT)        state_d = ST_EXT_BRK;
               else if (b == PS2_BREAK) state_d = ST_BRK;
               else                     state_d = ST_IDLE;
            ST_EXT_BRK:
               if (b == PS2_EXT || b == PS2_BREAK)
                  state_d = ST_EXT_BRK;
               else
                  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      do_make = 1'b0;
      do_brk  = 1'b0;
      is_ext  = 1'b0;
      if (new_byte) begin
         unique case (state_q)
            ST_IDLE:
               do_make = !(b == PS2_EXT   || b == PS2_BREAK ||
                           b == PS2_PAUSE || b == PS2_BAT   ||
                           b == PS2_ACK   || b == PS2_RESEND ||
                           b == PS2_ECHO);
            ST_EXT: begin
               do_make = (b != PS2_EXT) && (b != PS2_BREAK);
               is_ext  = 1'b1;
            end
            ST_BRK:
               do_brk = (b != PS2_EXT) && (b != PS2_BREAK);
            ST_EXT_BRK: begin
               do_brk = (b != PS2_EXT) && (b != PS2_BREAK);
               is_ext = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Only a change of the held bit produces an event; repeats are filtered.
   assign m        = map_code(b, is_ext);
   assign mask     = NUM_ACT'(1) << m.id;
   assign held     = |(key_state_q & mask);
   assign press_ev = do_make & m.hit & !held;
   assign rel_ev   = do_brk & m.hit & held;
   assign push     = press_ev | rel_ev;

   always_comb begin
      key_state_d = key_state_q;
      if (press_ev) key_state_d = key_state_q | mask;
      if (rel_ev)   key_state_d = key_state_q & ~mask;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q      <= '0;
         key_state_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         prev_q      <= keycode_in;
         key_state_q <= key_state_d;
         if (push & fifo_full & !(!fifo_empty & ev_ready))
            overflow_q <= 1'b1;
      end
   end

   action_event_fifo #(
      .WIDTH (5),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LEVEL_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (push),
      .data_i  ({press_ev, m.id}),
      .ready_i (ev_ready),
      .valid_o (ev_valid),
      .data_o  (fifo_dout),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign ev_press  = fifo_dout[4];
   assign ev_action = fifo_dout[3:0];
   assign key_state = key_state_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_keyboard_action_scheduler.sv
// Directed bench for keyboard_action_scheduler: decode, held-key
// filtering, FIFO fill/overflow/drain and mid-stream reset.
module tb_keyboard_action_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] kc = '0;
   logic        ev_ready = 1'b1;
   logic        ev_valid, ev_press, overflow;
   logic [3:0]  ev_action;
   logic [9:0]  key_state;
   logic [2:0]  fifo_level;

   int total = 0;
   int bad   = 0;

   keyboard_action_scheduler #(
      .FIFO_DEPTH (4),
      .LEVEL_W    (3)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .keycode_in (kc),
      .ev_ready   (ev_ready),
      .ev_valid   (ev_valid),
      .ev_press   (ev_press),
      .ev_action  (ev_action),
      .key_state  (key_state),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ev(input string tag, input logic v,
                         input logic p, input logic [3:0] a);
      chk({tag, ".valid"}, 32'(ev_valid), 32'(v));
      if (v) begin
         chk({tag, ".press"}, 32'(ev_press), 32'(p));
         chk({tag, ".action"}, 32'(ev_action), 32'(a));
      end
   endtask

   // Shift one byte into the receiver word; return just after the edge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      kc = {kc[23:0], b};
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_a [4];

      @(negedge clk);
      chk("rst.valid", 32'(ev_valid), 0);
      chk("rst.press", 32'(ev_press), 0);
      chk("rst.action", 32'(ev_action), 0);
      chk("rst.keys", 32'(key_state), 0);
      chk("rst.level", 32'(fifo_level), 0);
      chk("rst.ovf", 32'(overflow), 0);
      @(negedge clk);
      reset_n = 1'b1;

      send(8'h1D);
      chk_ev("w_make", 1, 1, 0);
      chk("w_make.keys", 32'(key_state), 32'h001);
      chk("w_make.level", 32'(fifo_level), 1);
      send(8'hF0);
      chk("w_f0.valid", 32'(ev_valid), 0);
      chk("w_f0.keys", 32'(key_state), 32'h001);
      send(8'h1D);
      chk_ev("w_brk", 1, 0, 0);
      chk("w_brk.keys", 32'(key_state), 32'h000);
      chk("w_brk.ovf", 32'(overflow), 0);

      send(8'hE0);
      chk("e0.valid", 32'(ev_valid), 0);
      send(8'h75);
      chk_ev("p2up_make", 1, 1, 5);
      chk("p2up_make.keys", 32'(key_state), 32'h020);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk_ev("p2up_brk", 1, 0, 5);
      chk("p2up_brk.keys", 32'(key_state), 32'h000);
      send(8'h75);
      chk("lone75.valid", 32'(ev_valid), 0);
      chk("lone75.keys", 32'(key_state), 32'h000);

      send(8'h1C);
      chk_ev("typ1", 1, 1, 2);
      send(8'h1C);
      chk("typ2.valid", 32'(ev_valid), 0);
      send(8'h1C);
      chk("typ3.valid", 32'(ev_valid), 0);
      chk("typ3.keys", 32'(key_state), 32'h004);
      send(8'hF0);
      send(8'h1C);
      chk_ev("typ_brk", 1, 0, 2);
      chk("typ_brk.keys", 32'(key_state), 32'h000);
      send(8'hF0);
      send(8'h1B);
      chk("stray_brk.valid", 32'(ev_valid), 0);

      ev_ready = 1'b0;
      send(8'h1D);
      send(8'h1B);
      send(8'h1C);
      send(8'h23);
      chk("fill4.ovf", 32'(overflow), 0);
      send(8'h29);
      send(8'hE0);
      send(8'h72);
      chk("ovf.level", 32'(fifo_level), 4);
      chk("ovf.ovf", 32'(overflow), 1);
      chk("ovf.keys", 32'(key_state), 32'h05F);
      exp_a = '{4'd0, 4'd1, 4'd2, 4'd3};
      ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_ev($sformatf("drain%0d", i), 1, 1, exp_a[i]);
         @(posedge clk);
         #1;
      end
      chk("drained.valid", 32'(ev_valid), 0);
      chk("drained.level", 32'(fifo_level), 0);

      send(8'hF0);
      reset_n = 1'b0;
      kc = '0;
      #1;
      chk("mid_rst.valid", 32'(ev_valid), 0);
      chk("mid_rst.press", 32'(ev_press), 0);
      chk("mid_rst.action", 32'(ev_action), 0);
      chk("mid_rst.keys", 32'(key_state), 0);
      chk("mid_rst.level", 32'(fifo_level), 0);
      chk("mid_rst.ovf", 32'(overflow), 0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      send(8'h29);
      chk_ev("post_rst", 1, 1, 4);
      chk("post_rst.keys", 32'(key_state), 32'h010);

      ev_ready = 1'b0;
      send(8'h1D);
      send(8'h1B);
      send(8'h1C);
      chk("full.level", 32'(fifo_level), 4);
      @(negedge clk);
      kc = {kc[23:0], 8'h23};
      ev_ready = 1'b1;
      @(posedge clk);
      #1;
      ev_ready = 1'b0;
      chk("pushpop.level", 32'(fifo_level), 4);
      chk("pushpop.ovf", 32'(overflow), 0);
      chk("pushpop.keys", 32'(key_state), 32'h01F);
      exp_a = '{4'd0, 4'd1, 4'd2, 4'd3};
      ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_ev($sformatf("pp_drain%0d", i), 1, 1, exp_a[i]);
         @(posedge clk);
         #1;
      end
      chk("pp_end.valid", 32'(ev_valid), 0);
      chk("pp_end.level", 32'(fifo_level), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keyboard_action_scheduler.md
Name: keyboard_action_scheduler

Overview:
- Sits between the PS/2 receiver's shifting 32-bit keycode word and the game logic.
- Detects each new scan byte and decodes Set-2 make/break/extended prefixes.
- Maps ten keys to player actions (two players × up/down/left/right/bomb) and keeps a held-key vector.
- Queues press/release events into a small FIFO drained by a valid/ready handshake, so game logic never misses short key taps.

Parameters:
- FIFO_DEPTH, 4, event queue entries; power of two, ≥2.
- LEVEL_W, 3, width of fifo_level; equals clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock; keycode_in must be synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- keycode_in  in  32  receiver word; the newest byte is in [7:0], shifted left 8 per received byte.
- ev_ready  in  1  consumer accepts the head event.
- ev_valid  out  1  head event present.
- ev_press  out  1  1 = press, 0 = release.
- ev_action  out  4  action id 0..9.
- key_state  out  10  held flag per action id.
- fifo_level  out  LEVEL_W  queued event count.
- overflow  out  1  sticky; an event was dropped.

Behaviour:
- Reset values: ev_valid=0, ev_press=0, ev_action=0, key_state=0, fifo_level=0, overflow=0, prev_word=0, FSM=IDLE. Reset mid-stream discards any partial prefix and all queued events.
- New-byte detect: a byte is new in any cycle where keycode_in != prev_word. prev_word <= keycode_in every cycle. Decode, key_state update and FIFO push all occur on that same edge.
  - Four identical consecutive bytes leave the word unchanged and are not detected. This is acceptable because typematic repeats are filtered anyway.
- Decoder FSM (byte b = keycode_in[7:0]):
  - IDLE: E0→EXT; F0→BRK; E1/AA/FA/FE/EE→IDLE, ignored; else make(b, ext=0)→IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; else make(b, ext=1)→IDLE.
  - BRK: E0→EXT_BRK; F0→BRK; else break(b, ext=0)→IDLE.
  - EXT_BRK: E0/F0→EXT_BRK; else break(b, ext=1)→IDLE.
- Action map:
  - Player 1, non-extended: 1D W→0 up; 1B S→1 down; 1C A→2 left; 23 D→3 right; 29 Space→4 bomb.
  - Player 2, extended: E0 75→5 up; E0 72→6 down; E0 6B→7 left; E0 74→8 right; E0 14 RCtrl→9 bomb.
  - Unmapped codes, and codes with the wrong ext flag, are ignored.
- Event generation:
  - make on a mapped id with key_state[id]=0: set the bit and push {1, id}.
  - break on a mapped id with key_state[id]=1: clear the bit and push {0, id}.
  - No change to the bit (typematic repeat, stray break): no push.
- FIFO:
  - Registered output, no bypass. A push into an empty queue raises ev_valid on the following cycle.
  - Pop when ev_valid & ev_ready.
  - Push while full without a same-cycle pop: drop the new event, set overflow (cleared only by reset). key_state still updates.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- ev_press and ev_action are stable while ev_valid & !ev_ready.

Decomposition:
- Shared package keyboard_pkg holds:
  - Prefix constants: PS2_EXT=E0, PS2_BREAK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, PS2_RESEND=FE, PS2_ECHO=EE.
  - Action id constants ACT_P1_UP..ACT_P2_BOMB.
  - The FSM state enum.
  - The scancode-to-action map function.
- One sub-module: action_event_fifo, a generic sync FIFO with parameters WIDTH=5 and DEPTH. It provides level, full, empty and a valid/ready read port.

Test Plan:
- Sequence 1D then F0,1D with ev_ready=1 → events {1,0} then {0,0}; key_state[0] goes 1 then 0; overflow=0.
- E0,75 then E0,F0,75 → events {1,5} then {0,5}. A lone 75 (no E0) → no event.
- Typematic 1C,1C,1C (word changes each byte) → exactly one event {1,2}; a later F0,1C → one event {0,2}.
- Hold ev_ready=0 and press six distinct mapped keys → fifo_level=4, overflow=1, key_state has 6 bits set. Draining yields the first four events in order.
- FIFO full, and a push coincides with ev_ready=1 → level stays 4, no overflow, new event appears last.
- Send F0 then assert reset_n=0, release, then send 29 → event {1,4}, not a release. All outputs are 0 during reset.
